dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4: consecutive denied host-request cycles before the host overrides CPU priority.
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum consecutive host grants while the CPU is requesting.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_adr in WIDTH, cpu_wd in WIDTH: the CPU data-memory access.
REQ-007 SHALL have ports cpu_rd out WIDTH (read data) and cpu_stall out 1 (CPU must hold PC and state this cycle).
REQ-008 SHALL have ports host_req in 1, host_we in 1, host_adr in WIDTH, host_wd in WIDTH: the host/loader access.
REQ-009 SHALL have ports host_gnt out 1 (host owns memory this cycle), host_rdata out WIDTH (registered read data) and host_rvalid out 1.
REQ-010 SHALL have ports mem_we out 1, mem_adr out WIDTH, mem_wd out WIDTH and mem_rd in WIDTH: the single-port data memory (combinational read, write on clock edge).

Function
REQ-011 SHALL hold a two-state FSM: S_CPU (reset state) and S_HOST.
REQ-012 SHALL hold wait_cnt, which saturates at MAX_WAIT, and burst_cnt, which saturates at BURST_MAX.
REQ-013 SHALL, in S_CPU, assert host_gnt combinationally iff host_req & (~cpu_req | wait_cnt == MAX_WAIT).
REQ-014 SHALL, in S_HOST, assert host_gnt combinationally iff host_req & (~cpu_req | burst_cnt < BURST_MAX).
REQ-015 SHALL drive cpu_stall = cpu_req & host_gnt, in the same cycle, with zero latency.
REQ-016 SHALL set next state to S_HOST when host_gnt=1 and to S_CPU otherwise.
REQ-017 SHALL update wait_cnt each cycle:
  - host_gnt=1 -> clear to 0.
  - host_req=1 & host_gnt=0 -> increment, saturating.
  - host_req=0 -> clear to 0.
REQ-018 SHALL update burst_cnt each cycle:
  - host_gnt=1 -> increment, saturating.
  - host_gnt=0 -> clear to 0.
REQ-019 SHALL route the memory port by owner:
  - host_gnt=1 -> mem_adr/mem_wd/mem_we from host_adr/host_wd/host_we.
  - otherwise -> from cpu_adr/cpu_wd/(cpu_we & cpu_req).
REQ-020 SHALL force mem_we=0 when neither side is granted (cpu_req=0 & host_gnt=0).
REQ-021 SHALL drive cpu_rd = mem_rd combinationally at all times; cpu_rd is meaningful only when cpu_stall=0.
REQ-022 SHALL handle host reads:
  - On a cycle with host_gnt=1 & host_we=0, capture mem_rd into host_rdata.
  - Pulse host_rvalid for exactly one cycle on the following cycle.
REQ-023 SHALL leave host_rdata unchanged on host writes and on non-granted cycles; host_rvalid=0 in those cases.
REQ-024 SHALL ensure at most one requester owns the memory in any cycle; a denied host must hold its request stable until granted.
REQ-025 SHALL make back-to-back host grants legal; each granted read produces its own host_rvalid pulse one cycle later.
REQ-026 SHALL guarantee the CPU regains ownership within BURST_MAX+1 cycles of host override, provided cpu_req stays high.
REQ-027 SHALL guarantee the host is granted within MAX_WAIT+1 cycles of asserting host_req.

Reset
REQ-028 SHALL, on a rising edge with reset=0, set state=S_CPU, wait_cnt=0, burst_cnt=0, host_rdata=0 and host_rvalid=0.
REQ-029 SHALL, while reset=0, force host_gnt=0, cpu_stall=0 and mem_we=0 combinationally.
REQ-030 SHALL, when reset is asserted mid-burst, abort the host ownership with no memory write on the reset cycle and no host_rvalid on the next cycle.

Verification
REQ-031 SHALL cover CPU only: cpu_req=1, cpu_we=1, cpu_adr=0x10, cpu_wd=0xDEADBEEF, host_req=0 -> mem_we=1, mem_adr=0x10, cpu_stall=0, next-cycle read of 0x10 returns 0xDEADBEEF.
REQ-032 SHALL cover host when idle: cpu_req=0, host_req=1, host_we=0, host_adr=0x10 -> host_gnt=1 same cycle; host_rvalid=1 and host_rdata=0xDEADBEEF next cycle.
REQ-033 SHALL cover starvation limit: cpu_req=1 and host_req=1 continuously, MAX_WAIT=4 -> host_gnt=0 for cycles 0-3, host_gnt=1 and cpu_stall=1 on cycle 4.
REQ-034 SHALL cover burst limit: both requesting continuously from host grant, BURST_MAX=4 -> host_gnt=1 for 4 cycles, then 0 for MAX_WAIT cycles, repeating with no deadlock.
REQ-035 SHALL cover reset mid-burst: reset=0 on the 2nd host-grant cycle -> host_gnt=0, mem_we=0, state=S_CPU, host_rvalid=0 on the following cycle.
REQ-036 SHALL cover simultaneous write conflict: cpu_we=1 and host_we=1 to the same address while host holds the grant -> only host_wd is written, cpu_stall=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a host
// loader, with bounded host starvation and bounded host bursts.
module dmem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_adr,
  input  logic [WIDTH-1:0] host_wd,
  output logic             host_gnt,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_rvalid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int WW = (MAX_WAIT  > 0) ? $clog2(MAX_WAIT + 1)  : 1;
  localparam int BW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_TOP = BW'(BURST_MAX);

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic            rvalid_n;

  // State, counters and host read-return registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_CPU;
      wait_cnt    <= '0;
      burst_cnt   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      burst_cnt   <= burst_n;
      host_rvalid <= rvalid_n;
      if (rvalid_n) host_rdata <= mem_rd;
    end
  end

  // Grant decision, next state, counter updates and memory-port routing.
  always_comb begin
    host_gnt  = 1'b0;
    state_n   = S_CPU;
    wait_n    = '0;
    burst_n   = '0;
    rvalid_n  = 1'b0;

    unique case (state)
      S_CPU:
        host_gnt = host_req &
                   (~cpu_req | (wait_cnt == WAIT_TOP));
      S_HOST:
        host_gnt = host_req &
                   (~cpu_req | (burst_cnt < BURST_TOP));
      default:
        host_gnt = 1'b0;
    endcase

    if (!reset) host_gnt = 1'b0;

    if (host_gnt) state_n = S_HOST;

    if (host_req & ~host_gnt)
      wait_n = (wait_cnt == WAIT_TOP) ? wait_cnt : wait_cnt + 1'b1;

    if (host_gnt)
      burst_n = (burst_cnt == BURST_TOP) ? burst_cnt : burst_cnt + 1'b1;

    rvalid_n  = host_gnt & ~host_we;
    cpu_stall = cpu_req & host_gnt;
    cpu_rd    = mem_rd;

    if (host_gnt) begin
      mem_adr = host_adr;
      mem_wd  = host_wd;
      mem_we  = host_we;
    end else begin
      mem_adr = cpu_adr;
      mem_wd  = cpu_wd;
      mem_we  = cpu_we & cpu_req;
    end

    if (!reset) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table for the arbitration corner cases
// followed by random traffic checked against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int MW = 4;
  localparam int BM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [W-1:0] cpu_adr, cpu_wd, cpu_rd;
  logic         cpu_stall;
  logic         host_req, host_we;
  logic [W-1:0] host_adr, host_wd, host_rdata;
  logic         host_gnt, host_rvalid;
  logic         mem_we;
  logic [W-1:0] mem_adr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we),
    .host_adr(host_adr), .host_wd(host_wd),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Single-port memory seen by the DUT: combinational read, edge write.
  logic [W-1:0] tbmem [256];
  logic         mem_clr;
  assign mem_rd = tbmem[mem_adr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= '0;
    end else if (mem_we) begin
      tbmem[mem_adr[7:0]] <= mem_wd;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         rst, cr, cw;
    logic [W-1:0] ca, cd;
    logic         hr, hw;
    logic [W-1:0] ha, hd;
    logic         g, s, we;
    logic [W-1:0] adr, rd;
    logic         rv;
    logic [W-1:0] rdat;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, cr, cw, input logic [W-1:0] ca, cd,
    input logic hr, hw, input logic [W-1:0] ha, hd,
    input logic g, s, we, input logic [W-1:0] adr, rd,
    input logic rv, input logic [W-1:0] rdat);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.g = g; v.s = s; v.we = we; v.adr = adr; v.rd = rd;
    v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  task automatic drive(input logic rst, cr, cw,
                       input logic [W-1:0] ca, cd,
                       input logic hr, hw,
                       input logic [W-1:0] ha, hd);
    reset = rst; cpu_req = cr; cpu_we = cw;
    cpu_adr = ca; cpu_wd = cd;
    host_req = hr; host_we = hw;
    host_adr = ha; host_wd = hd;
  endtask

  // Reference model state, phrased as streaks of host outcomes.
  logic [W-1:0] refmem [256];
  int           denied, streak;
  logic         m_rv;
  logic [W-1:0] m_rdata;

  localparam logic [W-1:0] D = 32'hDEADBEEF;
  localparam logic [W-1:0] P = 32'h12345678;

  vec_t tv [22];

  initial begin
    logic         g, s, we, hold;
    logic [W-1:0] adr, wd;
    tv[0]  = mk(1,1,1,'h10,D, 0,0,0,0,       0,0,1,'h10,0, 0,0);
    tv[1]  = mk(1,1,0,'h10,0, 0,0,0,0,       0,0,0,'h10,D, 0,0);
    tv[2]  = mk(1,0,0,'h10,0, 1,0,'h10,0,    1,0,0,'h10,D, 0,0);
    tv[3]  = mk(1,0,0,'h10,0, 0,0,0,0,       0,0,0,'h10,D, 1,D);
    for (int i = 4; i < 8; i++)
      tv[i] = mk(1,1,0,'h20,0, 1,1,'h30,P,   0,0,0,'h20,0, 0,D);
    tv[8]  = mk(1,1,0,'h20,0, 1,1,'h30,P,    1,1,1,'h30,0, 0,D);
    tv[9]  = mk(1,1,0,'h20,0, 1,0,'h10,0,    1,1,0,'h10,D, 0,D);
    tv[10] = mk(1,1,0,'h20,0, 1,0,'h10,0,    1,1,0,'h10,D, 1,D);
    tv[11] = mk(1,1,0,'h20,0, 1,0,'h10,0,    1,1,0,'h10,D, 1,D);
    tv[12] = mk(1,1,0,'h20,0, 1,0,'h10,0,    0,0,0,'h20,0, 1,D);
    for (int i = 13; i < 16; i++)
      tv[i] = mk(1,1,0,'h20,0, 1,0,'h10,0,   0,0,0,'h20,0, 0,D);
    tv[16] = mk(1,1,0,'h20,0, 1,0,'h10,0,    1,1,0,'h10,D, 0,D);
    tv[17] = mk(0,1,1,'h20,32'hCAFEF00D, 1,0,'h10,0,
                0,0,0,'h20,0, 1,D);
    tv[18] = mk(1,1,0,'h20,0, 1,0,'h10,0,    0,0,0,'h20,0, 0,0);
    tv[19] = mk(1,0,0,'h20,0, 1,1,'h40,32'hAAAA5555,
                1,0,1,'h40,0, 0,0);
    tv[20] = mk(1,1,1,'h40,32'h11112222, 1,1,'h40,32'h55556666,
                1,1,1,'h40,32'hAAAA5555, 0,0);
    tv[21] = mk(1,1,0,'h40,0, 0,0,0,0,
                0,0,0,'h40,32'h55556666, 0,0);

    // Reset with both sides requesting: nothing may be granted or written.
    mem_clr = 1'b1;
    drive(0,1,1,'h10,D, 1,1,'h10,P);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",    W'(host_gnt),    '0);
    chk("rst_stall",  W'(cpu_stall),   '0);
    chk("rst_mem_we", W'(mem_we),      '0);
    chk("rst_rvalid", W'(host_rvalid), '0);
    chk("rst_rdata",  host_rdata,      '0);

    foreach (tv[i]) begin
      @(negedge clk);
      mem_clr = 1'b0;
      drive(tv[i].rst, tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd,
            tv[i].hr, tv[i].hw, tv[i].ha, tv[i].hd);
      #1;
      chk($sformatf("v%0d_gnt", i),    W'(host_gnt),    W'(tv[i].g));
      chk($sformatf("v%0d_stall", i),  W'(cpu_stall),   W'(tv[i].s));
      chk($sformatf("v%0d_mem_we", i), W'(mem_we),      W'(tv[i].we));
      chk($sformatf("v%0d_mem_adr", i), mem_adr,        tv[i].adr);
      chk($sformatf("v%0d_cpu_rd", i), cpu_rd,          tv[i].rd);
      chk($sformatf("v%0d_rvalid", i), W'(host_rvalid), W'(tv[i].rv));
      chk($sformatf("v%0d_rdata", i),  host_rdata,      tv[i].rdat);
    end

    // Random traffic from a clean reset and cleared memory.
    @(negedge clk);
    mem_clr = 1'b1;
    drive(0,0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 256; i++) refmem[i] = '0;
    denied = 0; streak = 0; m_rv = 1'b0; m_rdata = '0;
    @(negedge clk);
    mem_clr = 1'b0;
    hold = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 59) != 0);
      cpu_req = ($urandom_range(0, 3) != 0);
      cpu_we  = $urandom_range(0, 1);
      cpu_adr = W'($urandom_range(0, 15));
      cpu_wd  = $urandom;
      if (!hold) begin
        host_req = ($urandom_range(0, 2) != 0);
        host_we  = $urandom_range(0, 1);
        host_adr = W'($urandom_range(0, 15));
        host_wd  = $urandom;
      end
      #1;
      if (!reset)        g = 1'b0;
      else if (!host_req) g = 1'b0;
      else if (!cpu_req)  g = 1'b1;
      else if (streak > 0) g = (streak < BM);
      else               g = (denied >= MW);
      s   = cpu_req & g;
      adr = g ? host_adr : cpu_adr;
      wd  = g ? host_wd : cpu_wd;
      we  = reset & (g ? host_we : (cpu_we & cpu_req));

      chk("r_gnt",    W'(host_gnt),    W'(g));
      chk("r_stall",  W'(cpu_stall),   W'(s));
      chk("r_mem_we", W'(mem_we),      W'(we));
      chk("r_mem_adr", mem_adr,        adr);
      if (we) chk("r_mem_wd", mem_wd, wd);
      chk("r_cpu_rd", cpu_rd,          refmem[adr[7:0]]);
      chk("r_rvalid", W'(host_rvalid), W'(m_rv));
      chk("r_rdata",  host_rdata,      m_rdata);

      if (!reset) begin
        denied = 0; streak = 0; m_rv = 1'b0; m_rdata = '0;
        hold = 1'b0;
      end else begin
        streak = g ? ((streak < BM) ? streak + 1 : BM) : 0;
        denied = (host_req && !g) ?
                 ((denied < MW) ? denied + 1 : MW) : 0;
        m_rv = g & ~host_we;
        if (m_rv) m_rdata = refmem[host_adr[7:0]];
        if (we) refmem[adr[7:0]] = wd;
        hold = host_req & ~g;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
